// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: DATA_BITS data, optional parity, 1-2 stop bits,
// zero-gap streaming via start/ready. Define UART_TX_BREAK_EN to add the brk input.
module uart_tx_cfg #(
  parameter int unsigned DIVISOR   = 1250,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 tx,
  output logic                 ready,
  output logic                 busy
);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_tx_cfg: DIVISOR must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(DIVISOR - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MAB
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [3:0]             bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   tx_q;
  logic                   ready_q;
  logic                   busy_q;

  logic last_tick;
  logic frame_end;
  logic brk_go;
  logic accept;

  assign last_tick = (cnt_q == CNT_MAX);
  assign frame_end = (state_q == S_STOP) && (bit_q == STOP_LAST) && last_tick;
`ifdef UART_TX_BREAK_EN
  // break is only honoured between frames and wins over a pending start
  assign brk_go = brk && ((state_q == S_IDLE) || frame_end);
`else
  assign brk_go = 1'b0;
`endif
  assign accept = start && ready_q && !brk_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else if (brk_go) begin
      state_q <= S_BREAK;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else if (accept) begin
      state_q <= S_START;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= data;
      par_q   <= (^data) ^ (PARITY == 2);
      tx_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      cnt_q <= last_tick ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_IDLE: cnt_q <= '0;
        S_START: begin
          if (last_tick) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        S_DATA: begin
          if (last_tick) begin
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        S_PARITY: begin
          if (last_tick) begin
            state_q <= S_STOP;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
        end
        S_STOP: begin
          // ready is registered, so raise it one cycle ahead of the final stop cycle
          if (bit_q == STOP_LAST && cnt_q == CNT_PRE) ready_q <= 1'b1;
          if (last_tick) begin
            if (bit_q == STOP_LAST) begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          cnt_q <= '0;
          if (!brk) begin
            state_q <= S_MAB;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
        end
        S_MAB: begin
          if (last_tick) begin
            if (bit_q == STOP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three parameterisations share one clock; expected
// per-cycle line levels are queued when a word is launched and popped each cycle.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [7:0] data0 = '0;
  logic [6:0] data1 = '0;
  logic [8:0] data2 = '0;
  logic [2:0] tx_v, rdy_v, bsy_v;
`ifdef UART_TX_BREAK_EN
  logic brk = 1'b0;
  logic brk_off = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_cfg #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data(data0),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .tx(tx_v[0]), .ready(rdy_v[0]), .busy(bsy_v[0]));

  uart_tx_cfg #(.DIVISOR(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data(data1),
`ifdef UART_TX_BREAK_EN
    .brk(brk_off),
`endif
    .tx(tx_v[1]), .ready(rdy_v[1]), .busy(bsy_v[1]));

  uart_tx_cfg #(.DIVISOR(3), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .data(data2),
`ifdef UART_TX_BREAK_EN
    .brk(brk_off),
`endif
    .tx(tx_v[2]), .ready(rdy_v[2]), .busy(bsy_v[2]));

  typedef struct packed { logic tx; logic rdy; } exp_t;
  typedef struct packed { logic st; logic [8:0] d; } drv_t;

  exp_t  exp_q[$];
  drv_t  drv_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  string tname = "reset";
  bit    noise = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %b expected %b", tname, tag, obs, expv);
    end
  endtask

  task automatic set_in(input int sel, input logic st, input logic [8:0] d);
    start_v[sel] = st;
    case (sel)
      0: data0 = d[7:0];
      1: data1 = d[6:0];
      default: data2 = d;
    endcase
  endtask

  task automatic push_frame(input int sel, input logic [8:0] d,
                            input logic nst, input logic [8:0] nd);
    int div, nb, pm, sb;
    logic p;
    logic bits[$];
    case (sel)
      0: begin div = 4; nb = 8; pm = 0; sb = 1; end
      1: begin div = 4; nb = 7; pm = 1; sb = 2; end
      default: begin div = 3; nb = 9; pm = 2; sb = 1; end
    endcase
    bits.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pm == 1) bits.push_back(p);
    if (pm == 2) bits.push_back(~p);
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < div; c++)
        exp_q.push_back('{tx: bits[b], rdy: (b == bits.size() - 1) && (c == div - 1)});
    drv_q.push_back('{st: nst, d: nd});
  endtask

  task automatic check_q(input int sel);
    exp_t e;
    drv_t dv;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk("tx", tx_v[sel], e.tx);
      chk("busy", bsy_v[sel], 1'b1);
      chk("ready", rdy_v[sel], e.rdy);
      if (e.rdy) begin
        dv = drv_q.pop_front();
        set_in(sel, dv.st, dv.d);
      end else if (noise) begin
        set_in(sel, 1'($urandom_range(1)), 9'($urandom));
      end
    end
  endtask

  task automatic check_idle(input int sel);
    @(negedge clk);
    chk("idle_tx", tx_v[sel], 1'b1);
    chk("idle_ready", rdy_v[sel], 1'b1);
    chk("idle_busy", bsy_v[sel], 1'b0);
  endtask

  task automatic send(input int sel, input logic [8:0] d);
    @(negedge clk);
    chk("pre_ready", rdy_v[sel], 1'b1);
    set_in(sel, 1'b1, d);
    push_frame(sel, d, 1'b0, 9'h000);
    check_q(sel);
    check_idle(sel);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_tx", tx_v[s], 1'b1);
      chk("rst_ready", rdy_v[s], 1'b1);
      chk("rst_busy", bsy_v[s], 1'b0);
    end
    rst = 1'b0;

    // 8N1 with 0xA5; mid-frame start/data noise must be ignored
    tname = "8n1_a5";
    noise = 1'b1;
    send(0, 9'h0A5);
    noise = 1'b0;

    tname = "7e2_41";
    send(1, 9'h041);

    tname = "9o1_1ff";
    send(2, 9'h1FF);

    // held start: two frames back to back, no mark gap
    tname = "stream";
    @(negedge clk);
    set_in(0, 1'b1, 9'h000);
    push_frame(0, 9'h000, 1'b1, 9'h0FF);
    push_frame(0, 9'h0FF, 1'b0, 9'h000);
    check_q(0);
    check_idle(0);

    // reset during data bit 3 of 0x3C, with start also high
    tname = "midrst";
    @(negedge clk);
    set_in(0, 1'b1, 9'h03C);
    @(negedge clk);
    set_in(0, 1'b0, 9'h000);
    chk("start_bit", tx_v[0], 1'b0);
    repeat (16) @(negedge clk);
    chk("bit3", tx_v[0], 1'b1);
    chk("bit3_busy", bsy_v[0], 1'b1);
    rst = 1'b1;
    set_in(0, 1'b1, 9'h0AA);
    @(negedge clk);
    chk("rst_tx", tx_v[0], 1'b1);
    chk("rst_ready", rdy_v[0], 1'b1);
    chk("rst_busy", bsy_v[0], 1'b0);
    rst = 1'b0;
    set_in(0, 1'b0, 9'h000);
    check_idle(0);
    send(0, 9'h055);

`ifdef UART_TX_BREAK_EN
    tname = "break";
    @(negedge clk);
    brk = 1'b1;
    set_in(0, 1'b1, 9'h05A);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("brk_tx", tx_v[0], 1'b0);
      chk("brk_busy", bsy_v[0], 1'b1);
      chk("brk_ready", rdy_v[0], 1'b0);
    end
    brk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mab_tx", tx_v[0], 1'b1);
      chk("mab_busy", bsy_v[0], 1'b1);
      chk("mab_ready", rdy_v[0], 1'b0);
    end
    check_idle(0);
    push_frame(0, 9'h05A, 1'b0, 9'h000);
    check_q(0);
    check_idle(0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
